// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_pkg;

    // Controller state: idle, presenting a trap redirect, presenting an MRET redirect.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_RET  = 2'd2
    } trap_state_e;

    // Exception cause codes (mcause with interrupt bit clear).
    localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
    localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;

    // Fixed-priority interrupt indices ahead of the platform lines (16 and up).
    localparam int IRQ_IDX_MEI      = 11;
    localparam int IRQ_IDX_MSI      = 3;
    localparam int IRQ_IDX_MTI      = 7;
    localparam int IRQ_IDX_PLAT_LO  = 16;

    // CSR addresses owned by this block.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Bit positions inside mstatus.
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_irq_prio.sv
// Picks the highest-priority interrupt from an already-masked pending vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is consumed.
// Ports: irq_i (masked pending lines) -> irq_vld_o (any eligible line), irq_code_o (winning index).
// Priority: 11 > 3 > 7 > 16..NUM_IRQ-1 with the lowest platform index first; all other lines are ignored.
module trap_irq_prio
    import trap_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               irq_vld_o,
    output logic [4:0]         irq_code_o
);

    // Lines 0-2, 4-6, 8-10 and 12-15 have no architectural meaning here.
    logic unused_irq_lines;
    assign unused_irq_lines = ^irq_i;

    always_comb begin
        irq_vld_o  = 1'b0;
        irq_code_o = 5'd0;
        // Walk the platform lines from the top down so the lowest index is written last and wins.
        for (int i = NUM_IRQ - 1; i >= IRQ_IDX_PLAT_LO; i--) begin
            if (irq_i[i]) begin
                irq_vld_o  = 1'b1;
                irq_code_o = 5'(i);
            end
        end
        // Standard lines override in ascending priority order: 7, then 3, then 11.
        if (irq_i[IRQ_IDX_MTI]) begin
            irq_vld_o  = 1'b1;
            irq_code_o = 5'(IRQ_IDX_MTI);
        end
        if (irq_i[IRQ_IDX_MSI]) begin
            irq_vld_o  = 1'b1;
            irq_code_o = 5'(IRQ_IDX_MSI);
        end
        if (irq_i[IRQ_IDX_MEI]) begin
            irq_vld_o  = 1'b1;
            irq_code_o = 5'(IRQ_IDX_MEI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts exceptions, interrupts and MRET, owns mstatus.MIE/MPIE, mepc, mcause, mtval.
// Latency: redirect_valid rises exactly one cycle after a request is accepted.
// Backpressure: redirect is held with a stable PC until redirect_ready; all requests and CSR writes are ignored meanwhile.
// Ports: exc_* exception report; mret_valid; cur_pc_valid/cur_pc interrupt boundary; irq_pending/csr_mie/csr_mtvec;
//        csr_we/csr_addr/csr_wdata software writes; redirect_valid/ready/pc fetch handshake; trap_busy and CSR readback.
// Option: define TRAP_VECTORED_EN to send interrupts to base + 4*code when csr_mtvec[1:0] == 2'b01.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid,
    input  logic               exc_ecall,
    input  logic               exc_ebreak,
    input  logic               exc_illegal,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               mret_valid,
    input  logic               cur_pc_valid,
    input  logic [XLEN-1:0]    cur_pc,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [NUM_IRQ-1:0] csr_mie,
    input  logic [XLEN-1:0]    csr_mtvec,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic               redirect_valid,
    input  logic               redirect_ready,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               trap_busy,
    output logic               mstatus_mie,
    output logic               mstatus_mpie,
    output logic [XLEN-1:0]    mepc,
    output logic [XLEN-1:0]    mcause,
    output logic [XLEN-1:0]    mtval
);

    trap_state_e     state_q, state_d;
    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, redirect_pc_q;

    logic            take_exc, take_irq, take_mret;
    logic            irq_vld;
    logic [4:0]      irq_code;
    logic [4:0]      exc_code;
    logic [XLEN-1:0] exc_tval_sel;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_target;

    trap_irq_prio #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_prio (
        .irq_i      (irq_pending & csr_mie),
        .irq_vld_o  (irq_vld),
        .irq_code_o (irq_code)
    );

    // Exception classification; a report with no type flag is treated as illegal.
    always_comb begin
        exc_code     = CAUSE_ILLEGAL;
        exc_tval_sel = exc_tval;
        if (exc_ebreak) begin
            exc_code     = CAUSE_BREAKPOINT;
            exc_tval_sel = exc_pc;
        end else if (exc_illegal || !exc_ecall) begin
            exc_code     = CAUSE_ILLEGAL;
            exc_tval_sel = exc_tval;
        end else begin
            exc_code     = CAUSE_ECALL_M;
            exc_tval_sel = '0;
        end
    end

    assign trap_base = {csr_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign irq_target = (csr_mtvec[1:0] == 2'b01) ? trap_base + XLEN'({irq_code, 2'b00}) : trap_base;
`else
    // Mode bits are ignored: every trap goes to the base address.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec[1:0];
    assign irq_target        = trap_base;
`endif

    // Next-state and acceptance decode. Requests are only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        take_exc  = 1'b0;
        take_irq  = 1'b0;
        take_mret = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    take_exc = 1'b1;
                    state_d  = ST_TAKE;
                end else if (mret_valid) begin
                    take_mret = 1'b1;
                    state_d   = ST_RET;
                end else if (mie_q && cur_pc_valid && irq_vld) begin
                    take_irq = 1'b1;
                    state_d  = ST_TAKE;
                end
            end
            ST_TAKE, ST_RET: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q <= state_d;
            // Redirect PC is captured at acceptance so it cannot move while the handshake is pending.
            if (take_exc) begin
                mepc_q        <= {exc_pc[XLEN-1:2], 2'b00};
                mcause_q      <= XLEN'(exc_code);
                mtval_q       <= exc_tval_sel;
                mpie_q        <= mie_q;
                mie_q         <= 1'b0;
                redirect_pc_q <= trap_base;
            end else if (take_irq) begin
                mepc_q        <= {cur_pc[XLEN-1:2], 2'b00};
                mcause_q      <= {1'b1, (XLEN-1)'(irq_code)};
                mtval_q       <= '0;
                mpie_q        <= mie_q;
                mie_q         <= 1'b0;
                redirect_pc_q <= irq_target;
            end else if (take_mret) begin
                mie_q         <= mpie_q;
                mpie_q        <= 1'b1;
                redirect_pc_q <= mepc_q;
            end else if (csr_we && (state_q == ST_IDLE)) begin
                // Software writes lose to any acceptance in the same cycle (branches above).
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_q  <= csr_wdata[MSTATUS_MIE_BIT];
                        mpie_q <= csr_wdata[MSTATUS_MPIE_BIT];
                    end
                    CSR_MEPC:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause_q <= csr_wdata;
                    CSR_MTVAL:  mtval_q  <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign redirect_valid = (state_q != ST_IDLE);
    assign trap_busy      = (state_q != ST_IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign mstatus_mie    = mie_q;
    assign mstatus_mpie   = mpie_q;
    assign mepc           = mepc_q;
    assign mcause         = mcause_q;
    assign mtval          = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_trap_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               exc_valid, exc_ecall, exc_ebreak, exc_illegal;
    logic [XLEN-1:0]    exc_pc, exc_tval;
    logic               mret_valid, cur_pc_valid;
    logic [XLEN-1:0]    cur_pc;
    logic [NUM_IRQ-1:0] irq_pending, csr_mie;
    logic [XLEN-1:0]    csr_mtvec;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic               redirect_valid, redirect_ready;
    logic [XLEN-1:0]    redirect_pc;
    logic               trap_busy, mstatus_mie, mstatus_mpie;
    logic [XLEN-1:0]    mepc, mcause, mtval;

    int errors = 0;
    int checks = 0;

    trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_ecall      (exc_ecall),
        .exc_ebreak     (exc_ebreak),
        .exc_illegal    (exc_illegal),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .cur_pc_valid   (cur_pc_valid),
        .cur_pc         (cur_pc),
        .irq_pending    (irq_pending),
        .csr_mie        (csr_mie),
        .csr_mtvec      (csr_mtvec),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .trap_busy      (trap_busy),
        .mstatus_mie    (mstatus_mie),
        .mstatus_mpie   (mstatus_mpie),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtval          (mtval)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        exc_valid    = 0; exc_ecall = 0; exc_ebreak = 0; exc_illegal = 0;
        mret_valid   = 0; cur_pc_valid = 0;
        irq_pending  = '0;
        csr_we       = 0; csr_addr = '0; csr_wdata = '0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 0;
    endtask

    // Complete the pending redirect and confirm the return to IDLE.
    task automatic finish_redirect(input string tag);
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        chk({tag, "_idle"}, {31'd0, trap_busy}, 32'd0);
    endtask

    task automatic fire_irq(input string tag, input logic [NUM_IRQ-1:0] lines, input logic [31:0] exp_cause);
        csr_wr(12'h300, 32'h8);
        irq_pending = lines; csr_mie = '1; cur_pc_valid = 1; cur_pc = 32'h1234;
        tick();
        clear_req();
        chk(tag, mcause, exp_cause);
        finish_redirect(tag);
    endtask

    initial begin
        rst = 1; redirect_ready = 0; exc_pc = '0; exc_tval = '0; cur_pc = '0;
        csr_mie = '0; csr_mtvec = '0;
        clear_req();
        tick(); tick();
        rst = 0;

        // Reset values
        chk("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("rst_busy",  {31'd0, trap_busy}, 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);
        chk("rst_mepc",  mepc, 32'd0);
        chk("rst_mcause",mcause, 32'd0);
        chk("rst_mtval", mtval, 32'd0);
        chk("rst_mie",   {31'd0, mstatus_mie}, 32'd0);
        chk("rst_mpie",  {31'd0, mstatus_mpie}, 32'd0);

        // ECALL
        csr_mtvec = 32'h8000;
        exc_valid = 1; exc_ecall = 1; exc_pc = 32'h100;
        tick();
        clear_req();
        chk("ecall_rv",     {31'd0, redirect_valid}, 32'd1);
        chk("ecall_rpc",    redirect_pc, 32'h8000);
        chk("ecall_mepc",   mepc, 32'h100);
        chk("ecall_mcause", mcause, 32'd11);
        chk("ecall_mtval",  mtval, 32'd0);
        chk("ecall_mie",    {31'd0, mstatus_mie}, 32'd0);
        finish_redirect("ecall");

        // Interrupt: 11 beats 7
        csr_wr(12'h300, 32'h8);
        chk("csr_mie_set", {31'd0, mstatus_mie}, 32'd1);
        csr_mtvec = 32'h8001;
        irq_pending = 16'h0880; csr_mie = 16'h0880; cur_pc_valid = 1; cur_pc = 32'h200;
        tick();
        clear_req();
        chk("irq_mcause", mcause, 32'h8000000B);
        chk("irq_mepc",   mepc, 32'h200);
        chk("irq_mtval",  mtval, 32'd0);
        chk("irq_mie",    {31'd0, mstatus_mie}, 32'd0);
        chk("irq_mpie",   {31'd0, mstatus_mpie}, 32'd1);
`ifdef TRAP_VECTORED_EN
        chk("irq_rpc",    redirect_pc, 32'h802C);
`else
        chk("irq_rpc",    redirect_pc, 32'h8000);
`endif
        finish_redirect("irq");

        // MRET restores MIE
        mret_valid = 1;
        tick();
        clear_req();
        chk("mret_rv",   {31'd0, redirect_valid}, 32'd1);
        chk("mret_rpc",  redirect_pc, 32'h200);
        chk("mret_mie",  {31'd0, mstatus_mie}, 32'd1);
        chk("mret_mpie", {31'd0, mstatus_mpie}, 32'd1);
        finish_redirect("mret");

        // Exception beats MRET and interrupt; stall 5 cycles
        exc_valid = 1; exc_illegal = 1; exc_pc = 32'h303; exc_tval = 32'hDEADBEEF;
        mret_valid = 1; irq_pending = 16'h0800; csr_mie = 16'h0800; cur_pc_valid = 1; cur_pc = 32'h700;
        tick();
        chk("prio_mcause", mcause, 32'd2);
        chk("prio_mepc",   mepc, 32'h300);
        chk("prio_mtval",  mtval, 32'hDEADBEEF);
        chk("prio_mpie",   {31'd0, mstatus_mpie}, 32'd1);
        // Keep requests and a CSR write active: all must be ignored while busy.
        exc_ebreak = 1; csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h444;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_rv",     {31'd0, redirect_valid}, 32'd1);
            chk("stall_rpc",    redirect_pc, 32'h8000);
            chk("stall_mcause", mcause, 32'd2);
            chk("stall_mepc",   mepc, 32'h300);
        end
        clear_req();
        finish_redirect("stall");

        // Ebreak wins over illegal and ecall
        exc_valid = 1; exc_ebreak = 1; exc_illegal = 1; exc_ecall = 1; exc_pc = 32'h400;
        tick();
        clear_req();
        chk("ebrk_mcause", mcause, 32'd3);
        chk("ebrk_mtval",  mtval, 32'h400);
        finish_redirect("ebrk");

        // No flag -> illegal
        exc_valid = 1; exc_pc = 32'h500; exc_tval = 32'h0000ABCD;
        tick();
        clear_req();
        chk("noflag_mcause", mcause, 32'd2);
        chk("noflag_mtval",  mtval, 32'h0000ABCD);
        finish_redirect("noflag");

        // Interrupt priority ladder
        fire_irq("irq3",  16'h0088, 32'h80000003);
        fire_irq("irq7",  16'h0080, 32'h80000007);

        // Ignored lines and gating conditions
        csr_wr(12'h300, 32'h8);
        irq_pending = 16'h7021; csr_mie = '1; cur_pc_valid = 1;
        tick();
        chk("irq_ignored", {31'd0, trap_busy}, 32'd0);
        irq_pending = 16'h0800; cur_pc_valid = 0;
        tick();
        chk("irq_no_pcv", {31'd0, trap_busy}, 32'd0);
        cur_pc_valid = 1; csr_mie = 16'h0080;
        tick();
        chk("irq_masked", {31'd0, trap_busy}, 32'd0);
        clear_req();

        // Trap overrides same-cycle CSR write
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h0000_0900;
        exc_valid = 1; exc_ecall = 1; exc_pc = 32'h600;
        tick();
        clear_req();
        chk("ovr_mepc", mepc, 32'h600);
        finish_redirect("ovr");

        // Back-to-back: request held high is re-accepted one cycle after IDLE
        exc_valid = 1; exc_ecall = 1; exc_pc = 32'h700;
        tick();
        chk("b2b_take1", {31'd0, trap_busy}, 32'd1);
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        chk("b2b_idle", {31'd0, trap_busy}, 32'd0);
        tick();
        chk("b2b_take2", {31'd0, trap_busy}, 32'd1);
        clear_req();

        // Reset mid-handshake, with a request also present
        tick();
        rst = 1; exc_valid = 1; exc_ebreak = 1;
        tick();
        rst = 0;
        clear_req();
        chk("mid_rst_rv",    {31'd0, redirect_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, trap_busy}, 32'd0);
        chk("mid_rst_rpc",   redirect_pc, 32'd0);
        chk("mid_rst_mepc",  mepc, 32'd0);
        chk("mid_rst_mcause",mcause, 32'd0);
        chk("mid_rst_mtval", mtval, 32'd0);
        chk("mid_rst_mpie",  {31'd0, mstatus_mpie}, 32'd0);

        // Software CSR writes
        csr_wr(12'h341, 32'h103);
        chk("csr_mepc", mepc, 32'h100);
        csr_wr(12'h342, 32'h8000_0007);
        chk("csr_mcause", mcause, 32'h8000_0007);
        csr_wr(12'h343, 32'h5555_AAAA);
        chk("csr_mtval", mtval, 32'h5555_AAAA);
        csr_wr(12'h300, 32'h80);
        chk("csr_mstat_mie",  {31'd0, mstatus_mie}, 32'd0);
        chk("csr_mstat_mpie", {31'd0, mstatus_mpie}, 32'd1);
        csr_wr(12'h305, 32'hFFFF_FFFF);
        chk("csr_other_mepc", mepc, 32'h100);
        chk("csr_other_mtval", mtval, 32'h5555_AAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and CSR width.
REQ-002 SHALL have parameter NUM_IRQ, default 16, interrupt line count (legal range 12..32).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports exc_valid/exc_ecall/exc_ebreak/exc_illegal  in  1 each  synchronous exception report and its type flags.
REQ-006 SHALL have ports exc_pc, exc_tval  in  XLEN  faulting PC and illegal instruction word.
REQ-007 SHALL have ports mret_valid  in  1, cur_pc_valid  in  1, cur_pc  in  XLEN  MRET retire, instruction boundary, next-to-execute PC.
REQ-008 SHALL have ports irq_pending  in  NUM_IRQ, csr_mie  in  NUM_IRQ, csr_mtvec  in  XLEN  interrupt lines, enable mask, trap vector.
REQ-009 SHALL have ports csr_we  in  1, csr_addr  in  12, csr_wdata  in  XLEN  software CSR write.
REQ-010 SHALL have ports redirect_valid  out  1, redirect_ready  in  1, redirect_pc  out  XLEN  fetch redirect handshake.
REQ-011 SHALL have ports trap_busy  out  1, mstatus_mie/mstatus_mpie  out  1, mepc/mcause/mtval  out  XLEN  state and CSR readback.

Function
REQ-012 SHALL implement FSM IDLE, TAKE, RET; trap_busy = (state != IDLE); all request inputs ignored when not IDLE.
REQ-013 In IDLE, exc_valid SHALL win over mret_valid and interrupts; mret_valid SHALL win over interrupts.
REQ-014 Interrupt SHALL be taken only when mstatus_mie=1, cur_pc_valid=1, and (irq_pending & csr_mie) nonzero.
REQ-015 Interrupt priority SHALL be index 11 > 3 > 7 > indices 16..NUM_IRQ-1 ascending; all other indices ignored.
REQ-016 Exception type priority SHALL be ebreak(cause 3) > illegal(cause 2) > ecall(cause 11); exc_valid with no flag SHALL be treated as illegal.
REQ-017 On trap acceptance (IDLE->TAKE, same edge): mepc <= exc_pc (exception) or cur_pc (interrupt), bits[1:0] forced 0; mcause <= {interrupt bit at XLEN-1, code}; MPIE <= MIE; MIE <= 0.
REQ-018 mtval SHALL be loaded with exc_tval for illegal, exc_pc for ebreak, 0 for ecall and interrupts.
REQ-019 In TAKE, redirect_valid=1 and redirect_pc = {csr_mtvec[XLEN-1:2],2'b00} (see REQ-027); state holds until redirect_ready=1, then IDLE next cycle.
REQ-020 On mret_valid acceptance (IDLE->RET): MIE <= MPIE, MPIE <= 1; in RET redirect_valid=1, redirect_pc = mepc, held until redirect_ready.
REQ-021 Latency: redirect_valid SHALL assert exactly one cycle after acceptance; redirect_pc SHALL be stable while redirect_valid=1.
REQ-022 csr_we SHALL write mstatus (0x300: MIE bit 3, MPIE bit 7), mepc (0x341, [1:0] forced 0), mcause (0x342), mtval (0x343); other addresses ignored.
REQ-023 csr_we SHALL be ignored when not IDLE; a trap or MRET accepted in the same cycle SHALL override the write.
REQ-024 Back-to-back: a new request SHALL be accepted no earlier than the cycle after returning to IDLE.

Reset
REQ-025 rst SHALL force state IDLE, redirect_valid=0, redirect_pc=0, MIE=0, MPIE=0, mepc=0, mcause=0, mtval=0, trap_busy=0, regardless of state, including mid-handshake.
REQ-026 rst SHALL dominate every other input in the same cycle.

Configuration
REQ-027 Macro TRAP_VECTORED_EN: defined -> interrupt with csr_mtvec[1:0]=2'b01 redirects to base + 4*code, exceptions to base; undefined -> csr_mtvec[1:0] ignored, all traps to base.

Structure
REQ-028 Shared package trap_pkg SHALL hold cause-code constants, CSR address constants, FSM state typedef.
REQ-029 Interrupt selection SHALL be sub-module trap_irq_prio (masked pending in -> valid, code out, combinational).

Verification
REQ-030 exc_valid+exc_ecall, exc_pc=0x100, mtvec=0x8000 -> next cycle redirect 0x8000, mepc=0x100, mcause=11, mtval=0, MIE=0.
REQ-031 MIE=1, irq_pending[7] and [11] set and enabled, cur_pc=0x200 -> mcause=0x8000000B, mepc=0x200; with TRAP_VECTORED_EN and mtvec=0x8001 -> redirect 0x802C.
REQ-032 Trap then mret_valid -> redirect_pc=mepc, MIE restored to pre-trap value, MPIE=1.
REQ-033 exc_valid, mret_valid, enabled irq all same cycle -> exception taken; redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable, no new acceptance.
REQ-034 rst asserted while in TAKE with redirect_ready=0 -> next cycle all outputs at reset values; csr_we to 0x341 with 0x103 in IDLE -> mepc=0x100.
